// File: rtl/phy_link_tx_ctrl_pkg.sv
// Shared definitions for the PHY link transmit controller: link states, grant width, helpers.
package phy_link_tx_ctrl_pkg;

  // Grant index width; covers up to 8 requesters.
  localparam int GNT_W = 3;

  typedef enum logic [1:0] {
    ST_TRAIN   = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } link_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/phy_link_tx_ctrl_rr_arbiter.sv
// Round-robin priority search: first asserted req at or above ptr, wrapping.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter
  import phy_link_tx_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GNT_W-1:0] ptr,
  output logic             any,
  output logic [GNT_W-1:0] idx
);

  // Walk offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      int cand;
      cand = (int'(ptr) + off) % NREQ;
      if (req[cand]) begin
        any = 1'b1;
        idx = GNT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/phy_link_tx_ctrl.sv
// Link-layer TX controller: trains on PHY sync, then packet-locked round-robin onto the PHY word port.
// One cycle request-to-PHY latency; req_ready comes only from registered grant state.
module phy_link_tx_ctrl
  import phy_link_tx_ctrl_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 32,
  parameter int SYNC_CNT = 4
) (
  input  logic               clk_2f,
  input  logic               reset,
  input  logic               sincronizar_bus,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      data_in,
  output logic               valid_in,
  output logic               link_up,
  output logic [2:0]         gnt_id,
  output logic               abort,
  output logic [7:0]         recover_cnt
);

  link_state_e      state_q, state_d;
  logic [3:0]       sync_cnt_q, sync_cnt_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic [7:0]       rcnt_q, rcnt_d;

  logic             arb_any;
  logic [GNT_W-1:0] arb_idx;
  logic             sel_vld, sel_last, xfer;
  logic [DW-1:0]    sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .any (arb_any),
    .idx (arb_idx)
  );

  // Mux the grant holder's lane; written as a loop to avoid indexing with a wider grant value.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == GNT_W'(i)) begin
        sel_vld  = req_valid[i];
        sel_last = req_last[i];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_rdy
    assign req_ready[g] = (state_q == ST_ACTIVE) && gnt_vld_q && (gnt_q == GNT_W'(g));
  end

  assign xfer = (state_q == ST_ACTIVE) && gnt_vld_q && sel_vld;

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    rcnt_d     = rcnt_q;
    valid_d    = 1'b0;
    abort_d    = 1'b0;
    data_d     = data_q;

    // A word accepted on the sync-loss edge still goes out; otherwise idle states drive zero.
    if (xfer) begin
      data_d  = sel_data;
      valid_d = 1'b1;
    end else if (state_q != ST_ACTIVE) begin
      data_d = '0;
    end

    case (state_q)
      ST_TRAIN, ST_RECOVER: begin
        if (sincronizar_bus) begin
          if (sync_cnt_q == 4'(SYNC_CNT - 1)) begin
            state_d    = ST_ACTIVE;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end else begin
          sync_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (!sincronizar_bus) begin
          state_d    = ST_RECOVER;
          sync_cnt_d = '0;
          gnt_vld_d  = 1'b0;
          gnt_d      = '0;
          rcnt_d     = sat_inc8(rcnt_q);
          abort_d    = gnt_vld_q && !(xfer && sel_last);
        end else if (gnt_vld_q) begin
          if (xfer && sel_last) begin
            gnt_vld_d = 1'b0;
            gnt_d     = '0;
            ptr_d     = (gnt_q == GNT_W'(NREQ - 1)) ? '0 : gnt_q + GNT_W'(1);
          end
        end else if (arb_any) begin
          gnt_vld_d = 1'b1;
          gnt_d     = arb_idx;
        end
      end
      default: begin
        state_d    = ST_TRAIN;
        sync_cnt_d = '0;
        gnt_vld_d  = 1'b0;
        gnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_TRAIN;
      sync_cnt_q <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      abort_q    <= 1'b0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      abort_q    <= abort_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign data_in     = data_q;
  assign valid_in    = valid_q;
  assign link_up     = (state_q == ST_ACTIVE);
  assign gnt_id      = 3'(gnt_q);
  assign abort       = abort_q;
  assign recover_cnt = rcnt_q;

endmodule
